staff_scroll_display: RTL and testbench

Scrolling staff renderer for the synth's VGA output. It generates parametrised VGA timing and draws a five-line staff. Notes and chords arrive on a valid/ready stream and fill a left-to-right history of SLOTS columns; once full, the staff scrolls left by one slot per new note. Note writes are committed only at frame boundaries, so no frame ever shows a partial update. The block sits between the keyboard decode logic and the VGA DAC pins.

---
 rtl/staff_scroll_display.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_staff_scroll_display.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/staff_scroll_display.sv
// ---------------------------------------------------------------------------
// staff_scroll_display
//
// Scrolling music-staff renderer for the VGA output. It generates the VGA
// raster timing, draws a five-line staff and overlays a left-to-right
// history of up to SLOTS notes or chords. Once the history is full, each new
// note scrolls the staff left by one slot. Codes arrive on a one-deep
// valid/ready input. They are applied only on the commit cycle, which is
// the first pixel of the first blanked line, so no visible frame ever shows
// a half-updated history.
//
// Ports
//   pxlclk      in   1   pixel clock (the only clock)
//   reset       in   1   synchronous, active-high
//   note_valid  in   1   note_code is valid
//   note_code   in   4   0-6 single note DO..SI, 7-10 chords C/E/F/G,
//                        11 clear, 12-15 ignored
//   note_ready  out  1   a code can be accepted this cycle
//   H_SYNC      out  1   horizontal sync, active low
//   V_SYNC      out  1   vertical sync, active low
//   RGB         out  9   pixel colour {R[2:0],G[2:0],B[2:0]}
//   display_en  out  1   pixel on RGB is inside the active area
//   px          out 10   x of the pixel currently on RGB
//   py          out 10   y of the pixel currently on RGB
//   frame_tick  out  1   one-cycle pulse on the commit cycle
// ---------------------------------------------------------------------------
module staff_scroll_display #(
    parameter int         H_ACTIVE     = 640,
    parameter int         H_SYNC_START = 656,
    parameter int         H_SYNC_END   = 752,
    parameter int         H_TOTAL      = 800,
    parameter int         V_ACTIVE     = 400,
    parameter int         V_SYNC_START = 412,
    parameter int         V_SYNC_END   = 414,
    parameter int         V_TOTAL      = 449,
    parameter int         SLOTS        = 8,
    parameter int         SLOT_W_LOG2  = 6,
    parameter int         TOP          = 50,
    parameter int         SPACING      = 25,
    parameter int         THICKNESS    = 5,
    parameter int         R2           = 224,
    parameter logic [8:0] STAFF_RGB    = 9'h1FF,
    parameter logic [8:0] NOTE_RGB     = 9'h038
) (
    input  logic       pxlclk,
    input  logic       reset,
    input  logic       note_valid,
    input  logic [3:0] note_code,
    output logic       note_ready,
    output logic       H_SYNC,
    output logic       V_SYNC,
    output logic [8:0] RGB,
    output logic       display_en,
    output logic [9:0] px,
    output logic [9:0] py,
    output logic       frame_tick
);

    // Width of the slot fill counter (must hold 0..SLOTS) and of a slot index.
    localparam int CW = $clog2(SLOTS + 1);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    // Sized copies of the integer parameters, so every compare is width-matched.
    localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT_C    = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT_C    = 10'(V_ACTIVE);
    localparam logic [9:0]    HSS_C      = 10'(H_SYNC_START);
    localparam logic [9:0]    HSE_C      = 10'(H_SYNC_END);
    localparam logic [9:0]    VSS_C      = 10'(V_SYNC_START);
    localparam logic [9:0]    VSE_C      = 10'(V_SYNC_END);
    localparam logic [CW-1:0] SLOTS_C    = CW'(SLOTS);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [9:0]    LOW_MASK   = 10'((1 << SLOT_W_LOG2) - 1);
    localparam logic [9:0]    HALF_W     = 10'(1 << (SLOT_W_LOG2 - 1));
    localparam logic [9:0]    LEDGER_Y   = 10'(TOP + 5 * SPACING);
    localparam logic [9:0]    LEDGER_BOT = 10'(TOP + 5 * SPACING + THICKNESS);
    localparam logic [9:0]    HALF_SP    = 10'(SPACING >> 1);
    localparam logic [21:0]   R2_C       = 22'(R2);
    localparam logic [10:0]   LEDGER_HW  = 11'd14;

    // Raster position of the pixel being computed this cycle.
    logic [9:0] hcnt;
    logic [9:0] vcnt;

    // One-entry input buffer.
    logic       pending_full;
    logic [3:0] pending_code;

    // Note history. Entries at or above count are stale and never drawn.
    logic [3:0]    slot [SLOTS];
    logic [CW-1:0] count;

    logic commit;

    // Per-pixel drawing terms.
    logic [9:0]  idx;
    logic        in_hist;
    logic [3:0]  cur_code;
    logic [9:0]  cx;
    logic [10:0] dx;
    logic [10:0] adx;
    logic [21:0] dx2;
    logic [2:0]  mem_n [3];
    logic [2:0]  mem_v;
    logic [2:0]  hit;
    logic        has_zero;
    logic        on_ledger;
    logic        on_note;
    logic        on_staff;
    logic        active;
    logic [8:0]  colour;

    // The commit cycle is the first pixel of the first blanked line. Because
    // the slot buffer only changes here, the visible area always reads a
    // stable history.
    assign commit     = (hcnt == 10'd0) && (vcnt == V_ACT_C);
    assign frame_tick = commit;
    assign note_ready = ~pending_full;

    // Raster counters: hcnt wraps every line, vcnt advances on each wrap.
    always_ff @(posedge pxlclk) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end else begin
            hcnt <= hcnt + 10'd1;
        end
    end

    // Input buffer and fill count. A pending code blocks new input until it
    // is committed, so at most one code enters per frame. On the commit cycle
    // the buffer is still full, so acceptance never coincides with a commit.
    always_ff @(posedge pxlclk) begin
        if (reset) begin
            pending_full <= 1'b0;
            pending_code <= 4'd0;
            count        <= '0;
        end else if (commit && pending_full) begin
            pending_full <= 1'b0;
            if (pending_code <= 4'd10) begin
                if (count < SLOTS_C) begin
                    count <= count + COUNT_ONE;
                end
            end else if (pending_code == 4'd11) begin
                count <= '0;
            end
        end else if (note_valid && !pending_full) begin
            pending_full <= 1'b1;
            pending_code <= note_code;
        end
    end

    // Slot storage. It has no reset because clearing count hides every
    // entry. When the history is full, the oldest entry falls off slot 0 and
    // the new code lands in the last slot.
    always_ff @(posedge pxlclk) begin
        if (!reset && commit && pending_full && (pending_code <= 4'd10)) begin
            if (count < SLOTS_C) begin
                slot[count[SW-1:0]] <= pending_code;
            end else begin
                for (int i = 0; i < SLOTS - 1; i++) begin
                    slot[i] <= slot[i + 1];
                end
                slot[SLOTS - 1] <= pending_code;
            end
        end
    end

    // Column geometry. The slot centre is the start of the slot plus half a
    // slot. Because dx is squared, only |dx| is needed.
    assign idx      = hcnt >> SLOT_W_LOG2;
    assign in_hist  = idx < 10'(count);
    assign cur_code = slot[idx[SW-1:0]];
    assign cx       = (hcnt & ~LOW_MASK) | HALF_W;
    assign dx       = {1'b0, hcnt} - {1'b0, cx};
    assign adx      = dx[10] ? (11'd0 - dx) : dx;
    assign dx2      = 22'(adx) * 22'(adx);

    // Expand the slot code into up to three staff positions n (0 = the
    // ledger-line C). A single note uses only member 0.
    always_comb begin
        mem_n[0] = 3'd0;
        mem_n[1] = 3'd0;
        mem_n[2] = 3'd0;
        mem_v    = 3'b000;
        if (in_hist) begin
            case (cur_code)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                    mem_n[0] = cur_code[2:0];
                    mem_v    = 3'b001;
                end
                4'd7: begin
                    mem_n[0] = 3'd0; mem_n[1] = 3'd2; mem_n[2] = 3'd4;
                    mem_v    = 3'b111;
                end
                4'd8: begin
                    mem_n[0] = 3'd2; mem_n[1] = 3'd4; mem_n[2] = 3'd6;
                    mem_v    = 3'b111;
                end
                4'd9: begin
                    mem_n[0] = 3'd3; mem_n[1] = 3'd5; mem_n[2] = 3'd0;
                    mem_v    = 3'b111;
                end
                4'd10: begin
                    mem_n[0] = 3'd4; mem_n[1] = 3'd6; mem_n[2] = 3'd1;
                    mem_v    = 3'b111;
                end
                default: begin
                end
            endcase
        end
    end

    // One circular head test per chord member. Each step up in n moves the
    // head half a line pitch upward from the ledger line.
    for (genvar m = 0; m < 3; m++) begin : g_head
        logic [9:0]  cy;
        logic [10:0] dy;
        logic [10:0] ady;
        logic [21:0] dy2;

        assign cy     = LEDGER_Y - 10'(mem_n[m]) * HALF_SP;
        assign dy     = {1'b0, vcnt} - {1'b0, cy};
        assign ady    = dy[10] ? (11'd0 - dy) : dy;
        assign dy2    = 22'(ady) * 22'(ady);
        assign hit[m] = mem_v[m] && ((dx2 + dy2) <= R2_C);
    end

    // The ledger line is drawn under any slot that contains the low C.
    assign has_zero  = |(mem_v & {mem_n[2] == 3'd0, mem_n[1] == 3'd0, mem_n[0] == 3'd0});
    assign on_ledger = has_zero && (vcnt >= LEDGER_Y) && (vcnt <= LEDGER_BOT)
                       && (adx < LEDGER_HW);
    assign on_note   = (|hit) || on_ledger;

    // The five staff lines, each THICKNESS+1 rows tall.
    always_comb begin
        on_staff = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if ((vcnt >= 10'(TOP + k * SPACING)) &&
                (vcnt <= 10'(TOP + k * SPACING + THICKNESS))) begin
                on_staff = 1'b1;
            end
        end
    end

    // Notes sit on top of the staff. Blanking forces black.
    assign active = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);

    always_comb begin
        colour = 9'h000;
        if (active) begin
            if (on_note) begin
                colour = NOTE_RGB;
            end else if (on_staff) begin
                colour = STAFF_RGB;
            end
        end
    end

    // Output register. Colour, syncs, enable and coordinates all come from
    // the same counter value, so they stay aligned one cycle behind it.
    always_ff @(posedge pxlclk) begin
        if (reset) begin
            RGB        <= 9'h000;
            H_SYNC     <= 1'b1;
            V_SYNC     <= 1'b1;
            display_en <= 1'b0;
            px         <= 10'd0;
            py         <= 10'd0;
        end else begin
            RGB        <= colour;
            H_SYNC     <= !((hcnt >= HSS_C) && (hcnt < HSE_C));
            V_SYNC     <= !((vcnt >= VSS_C) && (vcnt < VSE_C));
            display_en <= active;
            px         <= hcnt;
            py         <= vcnt;
        end
    end

endmodule

// File: tb/tb_staff_scroll_display.sv
// ---------------------------------------------------------------------------
// tb_staff_scroll_display
//
// Self-checking bench for staff_scroll_display. The raster is shrunk so that
// many whole frames fit in a short run. The bench keeps a note history as a
// queue, and it paints each expected pixel directly from the geometric rules
// (circle test, ledger band, staff bands). Every cycle, it compares the full
// set of DUT outputs against that reference.
// ---------------------------------------------------------------------------
module tb_staff_scroll_display;

    localparam int H_ACTIVE     = 64;
    localparam int H_SYNC_START = 66;
    localparam int H_SYNC_END   = 70;
    localparam int H_TOTAL      = 72;
    localparam int V_ACTIVE     = 46;
    localparam int V_SYNC_START = 47;
    localparam int V_SYNC_END   = 49;
    localparam int V_TOTAL      = 50;
    localparam int SLOTS        = 4;
    localparam int SLOT_W_LOG2  = 4;
    localparam int TOP          = 2;
    localparam int SPACING      = 8;
    localparam int THICKNESS    = 1;
    localparam int R2           = 9;
    localparam logic [8:0] STAFF_RGB = 9'h1FF;
    localparam logic [8:0] NOTE_RGB  = 9'h038;
    localparam int FRAME        = H_TOTAL * V_TOTAL;

    logic       pxlclk = 1'b0;
    logic       reset = 1'b1;
    logic       note_valid = 1'b0;
    logic [3:0] note_code = 4'd0;
    logic       note_ready;
    logic       H_SYNC;
    logic       V_SYNC;
    logic [8:0] RGB;
    logic       display_en;
    logic [9:0] px;
    logic [9:0] py;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    // Reference state: the DUT's raster position, the buffered code and the
    // visible history (oldest first).
    int ch;
    int cv;
    bit pend;
    int pcode;
    int hist[$];
    bit accepted;

    logic [8:0] exp_rgb;
    logic       exp_hs;
    logic       exp_vs;
    logic       exp_de;
    logic [9:0] exp_px;
    logic [9:0] exp_py;
    logic       exp_ft;
    logic       exp_rdy;

    always #5 pxlclk = ~pxlclk;

    staff_scroll_display #(
        .H_ACTIVE(H_ACTIVE), .H_SYNC_START(H_SYNC_START), .H_SYNC_END(H_SYNC_END),
        .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE), .V_SYNC_START(V_SYNC_START),
        .V_SYNC_END(V_SYNC_END), .V_TOTAL(V_TOTAL), .SLOTS(SLOTS),
        .SLOT_W_LOG2(SLOT_W_LOG2), .TOP(TOP), .SPACING(SPACING),
        .THICKNESS(THICKNESS), .R2(R2), .STAFF_RGB(STAFF_RGB), .NOTE_RGB(NOTE_RGB)
    ) dut (
        .pxlclk(pxlclk),
        .reset(reset),
        .note_valid(note_valid),
        .note_code(note_code),
        .note_ready(note_ready),
        .H_SYNC(H_SYNC),
        .V_SYNC(V_SYNC),
        .RGB(RGB),
        .display_en(display_en),
        .px(px),
        .py(py),
        .frame_tick(frame_tick)
    );

    // Staff positions n used by each chord code.
    function automatic int chord_member(input int code, input int j);
        int tab [4][3];
        tab = '{'{0, 2, 4}, '{2, 4, 6}, '{3, 5, 0}, '{4, 6, 1}};
        return tab[code - 7][j];
    endfunction

    // Expected colour of pixel (h,v), painted from the drawing rules.
    function automatic logic [8:0] model_pixel(input int h, input int v);
        int w;
        int idx;
        int cx;
        int cy;
        int code;
        int ledger_y;
        int ns[$];
        bit on_note;
        bit on_staff;
        w        = 1 << SLOT_W_LOG2;
        ledger_y = TOP + 5 * SPACING;
        on_note  = 1'b0;
        on_staff = 1'b0;
        if (h >= H_ACTIVE || v >= V_ACTIVE) return 9'h000;
        idx = h / w;
        if (idx < hist.size()) begin
            code = hist[idx];
            if (code <= 6) ns.push_back(code);
            else for (int j = 0; j < 3; j++) ns.push_back(chord_member(code, j));
            cx = idx * w + w / 2;
            foreach (ns[i]) begin
                cy = ledger_y - (SPACING / 2) * ns[i];
                if ((h - cx) * (h - cx) + (v - cy) * (v - cy) <= R2) on_note = 1'b1;
                if (ns[i] == 0 && v >= ledger_y && v <= ledger_y + THICKNESS &&
                    (h - cx) < 14 && (cx - h) < 14) on_note = 1'b1;
            end
        end
        for (int k = 0; k < 5; k++) begin
            if (v >= TOP + k * SPACING && v <= TOP + k * SPACING + THICKNESS) on_staff = 1'b1;
        end
        if (on_note) return NOTE_RGB;
        if (on_staff) return STAFF_RGB;
        return 9'h000;
    endfunction

    // Apply a committed code to the reference history.
    task automatic commit_code(input int code);
        if (code <= 10) begin
            if (hist.size() == SLOTS) void'(hist.pop_front());
            hist.push_back(code);
        end else if (code == 11) begin
            hist.delete();
        end
    endtask

    // Compare all DUT outputs against the reference values for this cycle.
    // Reporting stops after a burst of errors so a broken design cannot
    // flood the log.
    task automatic checkOutput();
        if (errors < 40) begin
            checks++;
            assert ({RGB, display_en, px, py} === {exp_rgb, exp_de, exp_px, exp_py})
            else begin
                errors++;
                $error("[TB] FAIL pixel: rgb/de/px/py got %h/%b/%0d/%0d required %h/%b/%0d/%0d",
                       RGB, display_en, px, py, exp_rgb, exp_de, exp_px, exp_py);
            end
            checks++;
            assert ({H_SYNC, V_SYNC} === {exp_hs, exp_vs})
            else begin
                errors++;
                $error("[TB] FAIL sync at px=%0d py=%0d: hs/vs got %b/%b required %b/%b",
                       exp_px, exp_py, H_SYNC, V_SYNC, exp_hs, exp_vs);
            end
            checks++;
            assert ({note_ready, frame_tick} === {exp_rdy, exp_ft})
            else begin
                errors++;
                $error("[TB] FAIL handshake at h=%0d v=%0d: ready/tick got %b/%b required %b/%b",
                       ch, cv, note_ready, frame_tick, exp_rdy, exp_ft);
            end
        end
    endtask

    // Advance one clock. The reference predicts what the coming edge does,
    // and the outputs are checked on the following falling edge.
    task automatic tick();
        accepted = 1'b0;
        if (reset) begin
            ch = 0;
            cv = 0;
            pend = 1'b0;
            hist.delete();
            exp_rgb = 9'h000;
            exp_hs  = 1'b1;
            exp_vs  = 1'b1;
            exp_de  = 1'b0;
            exp_px  = 10'd0;
            exp_py  = 10'd0;
        end else begin
            exp_rgb = model_pixel(ch, cv);
            exp_hs  = !(ch >= H_SYNC_START && ch < H_SYNC_END);
            exp_vs  = !(cv >= V_SYNC_START && cv < V_SYNC_END);
            exp_de  = (ch < H_ACTIVE) && (cv < V_ACTIVE);
            exp_px  = 10'(ch);
            exp_py  = 10'(cv);
            if (ch == 0 && cv == V_ACTIVE && pend) begin
                commit_code(pcode);
                pend = 1'b0;
            end else if (note_valid && !pend) begin
                pend     = 1'b1;
                pcode    = int'(note_code);
                accepted = 1'b1;
            end
            ch++;
            if (ch == H_TOTAL) begin
                ch = 0;
                cv++;
                if (cv == V_TOTAL) cv = 0;
            end
        end
        exp_ft  = (ch == 0 && cv == V_ACTIVE);
        exp_rdy = !pend;
        @(posedge pxlclk);
        @(negedge pxlclk);
        checkOutput();
    endtask

    // Run until the raster counter reaches (h,v), with a two-frame bound.
    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        while (!(ch == h && cv == v) && n < 2 * FRAME) begin
            tick();
            n++;
        end
    endtask

    // Offer a code starting at the beginning of the given line, and hold it
    // until the reference accepts it.
    task automatic applyStimulus(input int code, input int line);
        int n;
        wait_pos(0, line);
        note_valid = 1'b1;
        note_code  = 4'(code);
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 2 * FRAME);
        note_valid = 1'b0;
        note_code  = 4'($urandom_range(0, 15));
    endtask

    // Send one code per frame. Each code is committed at the end of its
    // frame, and the following frame is verified pixel by pixel.
    task automatic send_and_commit(input int code);
        applyStimulus(code, $urandom_range(0, V_ACTIVE - 1));
        wait_pos(0, V_ACTIVE);
    endtask

    initial begin
        int scroll_seq [9];
        scroll_seq = '{0, 1, 2, 3, 4, 5, 6, 0, 1};

        $display("[TB] reset and raster timing");
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        $display("[TB] single note");
        applyStimulus(2, 10);
        wait_pos(0, V_ACTIVE);

        $display("[TB] scroll sequence");
        foreach (scroll_seq[i]) send_and_commit(scroll_seq[i]);

        $display("[TB] clear, chord with ledger, random notes, clear, no-op");
        send_and_commit(11);
        send_and_commit(7);
        send_and_commit($urandom_range(0, 10));
        send_and_commit($urandom_range(0, 10));
        send_and_commit(11);
        send_and_commit(13);

        $display("[TB] random code");
        send_and_commit($urandom_range(0, 15));

        $display("[TB] reset with a code pending");
        send_and_commit(9);
        applyStimulus(5, 20);
        repeat ($urandom_range(1, 40)) tick();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        wait_pos(0, V_ACTIVE);
        tick();
        wait_pos(0, V_ACTIVE);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
